// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler: N_SLOTS moving obstacles over N_LANES lanes, with a difficulty ramp,
// an internal frame-based spawn delay and same-lane spacing. OBSTACLE_SCHEDULER_PAUSE_EN adds pause_in.

module obstacle_slot #(
    parameter int POS_W   = 11,
    parameter int LANE_W  = 2,
    parameter int SPAWN_X = 1087
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              spawn,
    input  logic              move,
    input  logic [LANE_W-1:0] new_lane,
    input  logic [1:0]        new_sprite,
    input  logic [2:0]        speed,
    output logic              active,
    output logic [LANE_W-1:0] lane,
    output logic [POS_W-1:0]  pos,
    output logic [1:0]        sprite
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            pos    <= POS_W'(SPAWN_X);
            lane   <= '0;
            sprite <= '0;
        end else if (clr) begin
            active <= 1'b0;
            pos    <= POS_W'(SPAWN_X);
            lane   <= '0;
            sprite <= '0;
        end else if (spawn) begin
            // spawn wins over motion: a fresh obstacle holds SPAWN_X for its first edge
            active <= 1'b1;
            pos    <= POS_W'(SPAWN_X);
            lane   <= new_lane;
            sprite <= new_sprite;
        end else if (move && active) begin
            if (pos <= POS_W'(speed)) begin
                active <= 1'b0;
                pos    <= POS_W'(SPAWN_X);
            end else begin
                pos <= pos - POS_W'(speed);
            end
        end
    end
endmodule

module obstacle_scheduler #(
    parameter int N_SLOTS      = 10,
    parameter int N_LANES      = 3,
    parameter int POS_W        = 11,
    parameter int SPAWN_X      = 1087,
    parameter int LEVEL_PERIOD = 30,
    parameter int SPEED_BASE   = 1,
    parameter int SPEED_MAX    = 7,
    parameter int MIN_GAP      = 128,
    parameter int DELAY_SHIFT  = 2
) (
    input  logic                                                       clk_in,
    input  logic                                                       rst_n_in,
`ifdef OBSTACLE_SCHEDULER_PAUSE_EN
    input  logic                                                       pause_in,
`endif
    input  logic                                                       game_reset_in,
    input  logic                                                       frame_in,
    input  logic [11:0]                                                time_alive_in,
    input  logic [3:0]                                                 rand_delay_in,
    input  logic [1:0]                                                 rand_lane_in,
    input  logic [1:0]                                                 rand_sprite_in,
    output logic [N_SLOTS-1:0]                                         obs_active_out,
    output logic [N_SLOTS*((N_LANES <= 2) ? 1 : $clog2(N_LANES))-1:0]  obs_lane_out,
    output logic [N_SLOTS*POS_W-1:0]                                   obs_pos_out,
    output logic [N_SLOTS*2-1:0]                                       obs_sprite_out,
    output logic [3:0]                                                 active_count_out,
    output logic [2:0]                                                 speed_out,
    output logic                                                       spawn_pulse_out
);
    localparam int LANE_W = (N_LANES <= 2) ? 1 : $clog2(N_LANES);
    localparam int DLY_W  = 4 + DELAY_SHIFT;
    localparam logic [POS_W-1:0] GAP_EDGE = POS_W'(SPAWN_X - MIN_GAP);

    typedef enum logic [1:0] {IDLE, WAIT, SPAWN} state_t;

    state_t                          state;
    logic [DLY_W-1:0]                delay;
    logic                            spawn_pulse;
    logic [3:0]                      level;
    logic [2:0]                      speed;

    logic                            pause;
    logic                            frame;
    logic [N_SLOTS-1:0]              active;
    logic [N_SLOTS-1:0][LANE_W-1:0]  lane;
    logic [N_SLOTS-1:0][POS_W-1:0]   pos;
    logic [N_SLOTS-1:0][1:0]         sprite;

    logic [3:0]                      active_count;
    logic [N_LANES-1:0]              blocked;
    logic [LANE_W-1:0]               base_lane;
    logic [LANE_W-1:0]               pick_lane;
    logic                            lane_ok;
    int                              cand;
    logic [N_SLOTS-1:0]              free_oh;
    logic                            slot_ok;
    logic                            spawn_go;
    logic [N_SLOTS-1:0]              spawn_oh;

    logic [11:0]                     lvl_raw;
    logic [3:0]                      lvl_next;
    logic [4:0]                      spd_sum;
    logic [2:0]                      spd_next;

`ifdef OBSTACLE_SCHEDULER_PAUSE_EN
    assign pause = pause_in;
`else
    assign pause = 1'b0;
`endif
    assign frame = frame_in & ~pause;

    assign lvl_raw  = time_alive_in / 12'(LEVEL_PERIOD);
    assign lvl_next = (lvl_raw > 12'(N_SLOTS)) ? 4'(N_SLOTS) : lvl_raw[3:0];
    assign spd_sum  = 5'(SPEED_BASE) + {1'b0, lvl_next};
    assign spd_next = (spd_sum > 5'(SPEED_MAX)) ? 3'(SPEED_MAX) : spd_sum[2:0];

    always_comb begin
        active_count = '0;
        for (int i = 0; i < N_SLOTS; i++)
            active_count = active_count + 4'(active[i]);
    end

    // a lane is blocked while any of its obstacles is still within MIN_GAP of the spawn edge
    always_comb begin
        blocked = '0;
        for (int i = 0; i < N_SLOTS; i++)
            for (int l = 0; l < N_LANES; l++)
                if (active[i] && pos[i] > GAP_EDGE && lane[i] == LANE_W'(l))
                    blocked[l] = 1'b1;
    end

    assign base_lane = ({1'b0, rand_lane_in} >= 3'(N_LANES)) ? LANE_W'(N_LANES / 2)
                                                             : LANE_W'(rand_lane_in);

    // walk the rotation backwards so the lane nearest base_lane is the last (winning) write
    always_comb begin
        lane_ok   = 1'b0;
        pick_lane = '0;
        cand      = 0;
        for (int k = N_LANES - 1; k >= 0; k--) begin
            cand = (int'(base_lane) + k) % N_LANES;
            if (!blocked[cand]) begin
                lane_ok   = 1'b1;
                pick_lane = LANE_W'(cand);
            end
        end
    end

    always_comb begin
        slot_ok = 1'b0;
        free_oh = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--)
            if (!active[i]) begin
                slot_ok    = 1'b1;
                free_oh    = '0;
                free_oh[i] = 1'b1;
            end
    end

    assign spawn_go = (state == SPAWN) && !pause && (active_count < level) && lane_ok && slot_ok;
    assign spawn_oh = spawn_go ? free_oh : '0;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= IDLE;
            delay       <= '0;
            spawn_pulse <= 1'b0;
            level       <= '0;
            speed       <= 3'(SPEED_BASE);
        end else if (game_reset_in) begin
            state       <= IDLE;
            delay       <= '0;
            spawn_pulse <= 1'b0;
            level       <= '0;
            speed       <= 3'(SPEED_BASE);
        end else begin
            spawn_pulse <= 1'b0;
            if (!pause) begin
                level <= lvl_next;
                speed <= spd_next;
                case (state)
                    IDLE: begin
                        if (active_count < level) begin
                            delay <= DLY_W'(rand_delay_in) << DELAY_SHIFT;
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (delay == '0)
                            state <= SPAWN;
                        else if (frame)
                            delay <= delay - DLY_W'(1);
                    end
                    SPAWN: begin
                        if (active_count >= level) begin
                            state <= IDLE;
                        end else if (spawn_go) begin
                            spawn_pulse <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
        obstacle_slot #(
            .POS_W   (POS_W),
            .LANE_W  (LANE_W),
            .SPAWN_X (SPAWN_X)
        ) u_slot (
            .clk        (clk_in),
            .rst_n      (rst_n_in),
            .clr        (game_reset_in),
            .spawn      (spawn_oh[i]),
            .move       (frame),
            .new_lane   (pick_lane),
            .new_sprite (rand_sprite_in),
            .speed      (speed),
            .active     (active[i]),
            .lane       (lane[i]),
            .pos        (pos[i]),
            .sprite     (sprite[i])
        );
    end

    assign obs_active_out   = active;
    assign obs_lane_out     = lane;
    assign obs_pos_out      = pos;
    assign obs_sprite_out   = sprite;
    assign active_count_out = active_count;
    assign speed_out        = speed;
    assign spawn_pulse_out  = spawn_pulse;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboard bench for obstacle_scheduler: a rule-level model predicts every cycle's outputs,
// a separate monitor pops and compares them; a few directed checks cover the ramp and reset.
module tb_obstacle_scheduler;
    localparam int N   = 10;
    localparam int NL  = 3;
    localparam int LW  = 2;
    localparam int PW  = 11;
    localparam int SX  = 1087;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            game_reset = 1'b0;
    logic            frame = 1'b0;
    logic [11:0]     time_alive = '0;
    logic [3:0]      rand_delay = '0;
    logic [1:0]      rand_lane = '0;
    logic [1:0]      rand_sprite = '0;
    logic [N-1:0]    act;
    logic [N*LW-1:0] lane_o;
    logic [N*PW-1:0] pos_o;
    logic [N*2-1:0]  spr_o;
    logic [3:0]      cnt;
    logic [2:0]      speed;
    logic            pulse;

    obstacle_scheduler dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .game_reset_in    (game_reset),
        .frame_in         (frame),
        .time_alive_in    (time_alive),
        .rand_delay_in    (rand_delay),
        .rand_lane_in     (rand_lane),
        .rand_sprite_in   (rand_sprite),
        .obs_active_out   (act),
        .obs_lane_out     (lane_o),
        .obs_pos_out      (pos_o),
        .obs_sprite_out   (spr_o),
        .active_count_out (cnt),
        .speed_out        (speed),
        .spawn_pulse_out  (pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]    act;
        logic [N*LW-1:0] lane;
        logic [N*PW-1:0] pos;
        logic [N*2-1:0]  spr;
        logic [3:0]      cnt;
        logic [2:0]      speed;
        logic            pulse;
    } snap_t;

    snap_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    spawns = 0;
    bit    done = 1'b0;

    // model state, kept as plain integers
    int m_act[N], m_pos[N], m_lane[N], m_spr[N];
    int m_level, m_speed, m_phase, m_delay, m_pulse;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h @%0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_pos[i] = SX; m_lane[i] = 0; m_spr[i] = 0;
        end
        m_level = 0; m_speed = 1; m_phase = 0; m_delay = 0; m_pulse = 0;
    endtask

    task automatic model_step();
        int c, pick, slot, l0, nphase, ndelay, lv;
        bit blk[NL];
        snap_t s;
        if (!rst_n || game_reset) begin
            model_reset();
        end else begin
            c = 0;
            for (int i = 0; i < N; i++) c += m_act[i];
            nphase = m_phase; ndelay = m_delay; m_pulse = 0; slot = -1; pick = -1;
            if (m_phase == 0) begin
                if (c < m_level) begin ndelay = int'(rand_delay) * 4; nphase = 1; end
            end else if (m_phase == 1) begin
                if (m_delay == 0) nphase = 2;
                else if (frame) ndelay = m_delay - 1;
            end else begin
                if (c >= m_level) nphase = 0;
                else begin
                    for (int l = 0; l < NL; l++) blk[l] = 0;
                    for (int i = 0; i < N; i++)
                        if (m_act[i] != 0 && m_pos[i] > SX - 128) blk[m_lane[i]] = 1;
                    l0 = (int'(rand_lane) >= NL) ? NL / 2 : int'(rand_lane);
                    for (int k = 0; k < NL && pick < 0; k++)
                        if (!blk[(l0 + k) % NL]) pick = (l0 + k) % NL;
                    for (int i = 0; i < N && slot < 0; i++)
                        if (m_act[i] == 0) slot = i;
                    if (pick >= 0 && slot >= 0) begin nphase = 0; m_pulse = 1; end
                    else slot = -1;
                end
            end
            if (frame)
                for (int i = 0; i < N; i++)
                    if (m_act[i] != 0) begin
                        if (m_pos[i] <= m_speed) begin m_act[i] = 0; m_pos[i] = SX; end
                        else m_pos[i] -= m_speed;
                    end
            if (slot >= 0) begin
                m_act[slot] = 1; m_pos[slot] = SX; m_lane[slot] = pick; m_spr[slot] = int'(rand_sprite);
            end
            m_phase = nphase; m_delay = ndelay;
            lv = int'(time_alive) / 30;
            m_level = (lv > N) ? N : lv;
            m_speed = (1 + m_level > 7) ? 7 : 1 + m_level;
        end
        s = '0;
        c = 0;
        for (int i = 0; i < N; i++) begin
            s.act[i]             = (m_act[i] != 0);
            s.pos[i*PW +: PW]    = PW'(m_pos[i]);
            s.lane[i*LW +: LW]   = LW'(m_lane[i]);
            s.spr[i*2 +: 2]      = 2'(m_spr[i]);
            c += m_act[i];
        end
        s.cnt = 4'(c); s.speed = 3'(m_speed); s.pulse = (m_pulse != 0);
        exp_q.push_back(s);
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin : mon
        snap_t e;
        if (!done) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL queue_empty got=0 want=1 @%0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("active", 128'(act), 128'(e.act));
                chk("pos", 128'(pos_o), 128'(e.pos));
                chk("lane", 128'(lane_o), 128'(e.lane));
                chk("sprite", 128'(spr_o), 128'(e.spr));
                chk("count", 128'(cnt), 128'(e.cnt));
                chk("speed", 128'(speed), 128'(e.speed));
                chk("pulse", 128'(pulse), 128'(e.pulse));
                if (pulse) spawns++;
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic rand_in(input int frame_pct);
        frame       = ($urandom_range(99) < frame_pct);
        rand_delay  = 4'($urandom);
        rand_lane   = 2'($urandom);
        rand_sprite = 2'($urandom);
    endtask

    initial begin
        logic [N*PW-1:0] parked;
        int p, waited;
        bit seen;
        parked = {N{11'd1087}};

        repeat (3) cyc();
        rst_n = 1'b1;

        // build up activity, then reset mid-operation
        time_alive = 12'd200;
        repeat (300) begin cyc(); rand_in(80); end
        rst_n = 1'b0;
        cyc();
        chk("rst_active", 128'(act), 128'(0));
        chk("rst_pos", 128'(pos_o), 128'(parked));
        chk("rst_speed", 128'(speed), 128'(1));
        cyc();
        rst_n = 1'b1;
        time_alive = '0;
        p = 0;
        repeat (100) begin
            rand_in(100);
            frame = 1'b1;
            cyc();
            if (pulse) p++;
        end
        chk("idle_no_spawn", 128'(p), 128'(0));

        // ramp: first level, delay seed 3
        game_reset = 1'b1;
        cyc();
        game_reset = 1'b0;
        time_alive = 12'd30; rand_delay = 4'd3; rand_lane = 2'd0; frame = 1'b1;
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 100) begin
            cyc();
            waited++;
            seen = pulse;
        end
        chk("ramp_spawn_seen", 128'(seen), 128'(1));
        chk("ramp_slot0", 128'(act), 128'(1));
        chk("ramp_pos0", 128'(pos_o[PW-1:0]), 128'(SX));
        chk("ramp_speed", 128'(speed), 128'(2));

        time_alive = 12'd90;
        waited = 0;
        while (cnt < 4'd3 && waited < 400) begin
            rand_lane = 2'($urandom); rand_delay = 4'($urandom_range(3));
            cyc();
            waited++;
        end
        chk("ramp90_count", 128'(cnt), 128'(3));
        chk("ramp90_speed", 128'(speed), 128'(4));

        // long random run with level changes, resets and sparse/dense frames
        for (int seg = 0; seg < 12; seg++) begin
            time_alive = 12'($urandom_range(420));
            for (int k = 0; k < 400; k++) begin
                rand_in((seg % 3 == 0) ? 20 : 85);
                game_reset = ($urandom_range(999) == 0);
                cyc();
            end
            if (seg == 6) begin
                rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end
        end
        game_reset = 1'b0;
        cyc();
        done = 1'b1;
        total++;
        if (spawns < 20) begin
            bad++;
            $display("FAIL spawn_activity got=%0d want>=20", spawns);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
